// File: rtl/mod_updown_counter_pkg.sv
// ============================================================================
// counter_pkg : mode encodings shared by the up/down counter files
// Revision    : 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_MODULO  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b01;
  localparam logic [MODE_W-1:0] MODE_HOLD    = 2'b10;

  // Any mode with the hold bit set (10 or 11) freezes the counter.
  function automatic logic mode_counts(input logic [MODE_W-1:0] mode);
    return (mode & MODE_HOLD) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_updown_counter_if.sv
// ============================================================================
// mod_updown_counter_if : control and status bundle of the up/down counter
// Revision              : 1.0
// ============================================================================
`default_nettype none

interface mod_updown_counter_if #(
  parameter int WIDTH = 3
);
  import counter_pkg::*;

  logic                clear;
  logic                en;
  logic                up;
  logic [MODE_W-1:0]   mode;
  logic                load;
  logic [WIDTH-1:0]    load_val;
  logic [WIDTH-1:0]    q;
  logic                tc;
  logic                done;

  modport master (
    output clear, en, up, mode, load, load_val,
    input  q, tc, done
  );

  modport slave (
    input  clear, en, up, mode, load, load_val,
    output q, tc, done
  );

endinterface

`default_nettype wire

// File: rtl/mod_updown_counter_count_next_logic.sv
// ============================================================================
// count_next_logic : next count value and terminal/wrap events for one step
// Revision         : 1.0
// ============================================================================
`default_nettype none

module count_next_logic
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0]  q,
  input  logic              up,
  input  logic [MODE_W-1:0] mode,
  input  logic              done,
  output logic [WIDTH-1:0]  q_nxt,
  output logic              at_term,
  output logic              wrap
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);

  logic [WIDTH:0]   step_ext;
  logic             out_of_range;
  logic [WIDTH-1:0] term;

  always_comb begin
    step_ext     = up ? ({1'b0, q} + ONE_EXT) : ({1'b0, q} - ONE_EXT);
    // Down from 0 underflows to all ones, so one compare covers both wraps.
    out_of_range = step_ext > MAX_EXT;
    term         = up ? MAX_Q : '0;

    q_nxt   = q;
    at_term = 1'b0;
    wrap    = 1'b0;

    if (!done && mode_counts(mode)) begin
      if (mode == MODE_MODULO) begin
        wrap  = out_of_range;
        q_nxt = out_of_range ? (up ? '0 : MAX_Q) : step_ext[WIDTH-1:0];
      end else begin
        at_term = 1'b1;
        if (q != term) begin
          q_nxt   = step_ext[WIDTH-1:0];
          at_term = (step_ext[WIDTH-1:0] == term);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ============================================================================
// mod_updown_counter : synchronous up/down counter with modulus, load,
//                      one-shot mode and registered terminal-count pulse
// Revision           : 1.0
// ============================================================================
`default_nettype none

module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mod_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_clamped;
  logic             tc_reg;
  logic             tc_d;
  logic             done_reg;
  logic             done_d;
  logic             at_term;
  logic             wrap;

  count_next_logic #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q       (q_reg),
    .up      (bus.up),
    .mode    (bus.mode),
    .done    (done_reg),
    .q_nxt   (q_step),
    .at_term (at_term),
    .wrap    (wrap)
  );

  // Priority: clear > load > count > hold; tc is only ever a one-cycle pulse.
  always_comb begin
    load_clamped = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
    q_d          = q_reg;
    tc_d         = 1'b0;
    done_d       = done_reg;

    if (bus.clear) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (bus.load) begin
      q_d    = load_clamped;
      done_d = 1'b0;
    end else if (bus.en) begin
      q_d    = q_step;
      tc_d   = wrap | at_term;
      done_d = done_reg | at_term;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg    <= '0;
      tc_reg   <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_d;
      tc_reg   <= tc_d;
      done_reg <= done_d;
    end
  end

  assign bus.q    = q_reg;
  assign bus.tc   = tc_reg;
  assign bus.done = done_reg;

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
// ============================================================================
// tb_mod_updown_counter : table, directed and random checks of three counters
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_mod_updown_counter;
  import counter_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       en    = 1'b0;
  logic       up    = 1'b0;
  logic       load  = 1'b0;
  logic [1:0] mode  = 2'b00;
  logic [3:0] lv    = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(3)) if6 ();
  mod_updown_counter_if #(.WIDTH(3)) if8 ();
  mod_updown_counter_if #(.WIDTH(4)) if16 ();

  assign if6.clear     = clear;
  assign if6.en        = en;
  assign if6.up        = up;
  assign if6.mode      = mode;
  assign if6.load      = load;
  assign if6.load_val  = lv[2:0];
  assign if8.clear     = clear;
  assign if8.en        = en;
  assign if8.up        = up;
  assign if8.mode      = mode;
  assign if8.load      = load;
  assign if8.load_val  = lv[2:0];
  assign if16.clear    = clear;
  assign if16.en       = en;
  assign if16.up       = up;
  assign if16.mode     = mode;
  assign if16.load     = load;
  assign if16.load_val = lv;

  mod_updown_counter #(.WIDTH(3), .MODULUS(6))  dut6  (.clk(clk), .reset(reset), .bus(if6.slave));
  mod_updown_counter #(.WIDTH(3), .MODULUS(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));

  // Reference model: count value kept as an integer in 0..m-1.
  typedef struct {
    int q;
    bit tc;
    bit done;
  } mst_t;

  mst_t ms[3];
  int   mods[3] = '{6, 8, 16};
  int   wds[3]  = '{3, 3, 4};

  function automatic mst_t mstep(mst_t s, int m, int w);
    mst_t n;
    int   term;
    n    = s;
    n.tc = 1'b0;
    if (clear) begin
      n.q    = 0;
      n.done = 1'b0;
    end else if (load) begin
      n.q    = int'(lv) % (1 << w);
      if (n.q > m - 1) n.q = m - 1;
      n.done = 1'b0;
    end else if (en && mode < 2 && !s.done) begin
      term = up ? m - 1 : 0;
      if (mode == 0) begin
        n.q  = up ? (s.q + 1) % m : (s.q + m - 1) % m;
        n.tc = (n.q == (up ? 0 : m - 1));
      end else begin
        if (s.q != term) n.q = up ? s.q + 1 : s.q - 1;
        if (n.q == term) begin
          n.tc   = 1'b1;
          n.done = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic int get_q(int k);
    case (k)
      0:       return int'(if6.q);
      1:       return int'(if8.q);
      default: return int'(if16.q);
    endcase
  endfunction

  function automatic int get_tc(int k);
    case (k)
      0:       return int'(if6.tc);
      1:       return int'(if8.tc);
      default: return int'(if16.tc);
    endcase
  endfunction

  function automatic int get_done(int k);
    case (k)
      0:       return int'(if6.done);
      1:       return int'(if8.done);
      default: return int'(if16.done);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s m%0d q", tag, mods[k]), get_q(k), ms[k].q);
      chk($sformatf("%s m%0d tc", tag, mods[k]), get_tc(k), int'(ms[k].tc));
      chk($sformatf("%s m%0d done", tag, mods[k]), get_done(k), int'(ms[k].done));
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 3; k++) begin
      ms[k].q    = 0;
      ms[k].tc   = 1'b0;
      ms[k].done = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) ms[k] = mstep(ms[k], mods[k], wds[k]);
    #1;
  endtask

  // Directed vectors; expectations are for the MODULUS = 6 instance.
  typedef struct {
    bit       c;
    bit       e;
    bit       u;
    bit [1:0] md;
    bit       ld;
    bit [3:0] l;
    int       eq;
    bit       etc;
    bit       edn;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input bit c, input bit e, input bit u, input bit [1:0] md,
                      input bit ld, input bit [3:0] l, input int eq, input bit etc,
                      input bit edn);
    vec_t v;
    v = '{c, e, u, md, ld, l, eq, etc, edn};
    vecs.push_back(v);
  endtask

  initial begin
    int oq[6];
    int otc[6];
    int odn[6];

    for (int i = 0; i < 14; i++) addv(0, 1, 1, 0, 0, 0, (i + 1) % 6, ((i + 1) % 6) == 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 5, 1, 0);
    addv(0, 1, 0, 0, 0, 0, 4, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 3, 0, 0);
    addv(1, 1, 0, 0, 1, 7, 0, 0, 0);
    addv(0, 0, 0, 0, 1, 7, 5, 0, 0);
    for (int i = 0; i < 5; i++) addv(0, 0, 1, 0, 0, 0, 5, 0, 0);
    for (int i = 0; i < 5; i++) addv(0, 1, 1, 2, 0, 0, 5, 0, 0);
    addv(0, 1, 0, 3, 0, 0, 5, 0, 0);
    addv(0, 1, 1, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 0, 0, 0, 0, 5, 1, 0);
    addv(0, 1, 0, 0, 0, 0, 4, 0, 0);
    addv(0, 1, 1, 0, 0, 0, 5, 0, 0);
    addv(0, 0, 1, 1, 1, 3, 3, 0, 0);
    addv(0, 1, 1, 1, 0, 0, 4, 0, 0);
    addv(0, 1, 1, 1, 0, 0, 5, 1, 1);
    addv(0, 1, 1, 1, 0, 0, 5, 0, 1);
    addv(0, 0, 1, 1, 0, 0, 5, 0, 1);
    addv(0, 1, 0, 0, 0, 0, 5, 0, 1);
    addv(0, 1, 1, 2, 0, 0, 5, 0, 1);
    addv(0, 0, 0, 1, 1, 2, 2, 0, 0);
    addv(0, 1, 0, 1, 0, 0, 1, 0, 0);
    addv(0, 1, 0, 1, 0, 0, 0, 1, 1);
    addv(0, 1, 0, 1, 0, 0, 0, 0, 1);
    addv(1, 0, 0, 1, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 1, 0, 0, 0, 1, 1);
    addv(0, 1, 0, 1, 0, 0, 0, 0, 1);
    addv(1, 0, 0, 0, 0, 0, 0, 0, 0);

    reset_models();
    #12;
    chk("reset q", int'(if6.q), 0);
    chk("reset tc", int'(if6.tc), 0);
    chk("reset done", int'(if6.done), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].c;
      en    = vecs[i].e;
      up    = vecs[i].u;
      mode  = vecs[i].md;
      load  = vecs[i].ld;
      lv    = vecs[i].l;
      tick();
      chk($sformatf("vec%0d q", i), int'(if6.q), vecs[i].eq);
      chk($sformatf("vec%0d tc", i), int'(if6.tc), int'(vecs[i].etc));
      chk($sformatf("vec%0d done", i), int'(if6.done), int'(vecs[i].edn));
      chk_all($sformatf("vec%0d", i));
    end

    // One-shot up from a load of 3 with MODULUS = 8.
    clear = 0; en = 0; up = 1; mode = 2'b01; load = 1; lv = 4'd3;
    tick();
    chk("os8 load q", int'(if8.q), 3);
    load = 0;
    en   = 1;
    oq  = '{4, 5, 6, 7, 7, 7};
    otc = '{0, 0, 0, 1, 0, 0};
    odn = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("os8 step%0d q", i), int'(if8.q), oq[i]);
      chk($sformatf("os8 step%0d tc", i), int'(if8.tc), otc[i]);
      chk($sformatf("os8 step%0d done", i), int'(if8.done), odn[i]);
    end

    // Asynchronous reset in mid-cycle with the count at 5.
    clear = 1; en = 0; mode = 2'b00;
    tick();
    clear = 0;
    en    = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre-reset q", int'(if6.q), 5);
    #3;
    reset = 1'b0;
    #1;
    reset_models();
    chk("async reset q", int'(if6.q), 0);
    chk("async reset tc", int'(if6.tc), 0);
    chk("async reset done", int'(if6.done), 0);
    chk_all("async reset");
    en = 0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_all("post reset");

    for (int i = 0; i < 400; i++) begin
      int r;
      clear = ($urandom_range(19) == 0);
      load  = ($urandom_range(9) == 0);
      en    = ($urandom_range(3) != 0);
      up    = 1'($urandom_range(1));
      r     = int'($urandom_range(7));
      mode  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : 2'($urandom_range(3, 2));
      lv    = 4'($urandom_range(15));
      tick();
      chk_all($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
